fitness_eval: RTL
=================

# fitness_eval

Sequential fitness evaluator placed directly downstream of the evolvable logic-element grid. On a start request it sweeps every input combination into the grid's primary inputs. Each cycle it compares the grid's combinational outputs against a target truth table and accumulates the number of matching output bits. It then reports the fitness score, per-output error flags, and a running best score to the evolutionary controller.

## Interface
Parameters:
- IN, 4, number of grid primary inputs; sweep length is NV = 2^IN vectors
- OUT, 2, number of grid outputs compared
- FW, $clog2(OUT*2^IN+1), width of fitness values

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request evaluation; sampled only in IDLE
- clear_best  input  1  clears best_fitness; honored only in IDLE
- target  input  OUT*NV  expected truth table; bit k*NV+v is the expected value of output k for input vector v; must be stable while busy
- cand_inp  output  IN  drives grid inp
- cand_out  input  OUT  grid out; combinational function of cand_inp
- busy  output  1  high in SWEEP and DONE; the controller must hold the chromosome (saidas_LE, out_chrom) stable while high
- done  output  1  one-cycle pulse; fitness, err_mask and new_best valid
- fitness  output  FW  matching-bit count of the last completed evaluation
- perfect  output  1  fitness == OUT*NV, valid with fitness
- err_mask  output  OUT  bit k set if output k mismatched on any vector in the last evaluation
- best_fitness  output  FW  maximum fitness since reset or the last clear_best
- new_best  output  1  pulse with done when fitness > previous best_fitness

## Operation
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - cand_inp = 0.
  - On start: enter SWEEP, vec <= 0, score <= 0, err_acc <= 0.
  - If clear_best is asserted: best_fitness <= 0. When start and clear_best are both asserted, both take effect.
- SWEEP:
  - cand_inp = vec.
  - Per cycle, match = ~(cand_out ^ {target[k*NV+vec] for k}).
  - score += popcount(match); err_acc |= ~match.
  - When vec == NV-1: enter DONE. Otherwise vec++.
  - vec counter is IN+1 bits wide, so NV-1 is reachable without wrap ambiguity.
- DONE (one cycle):
  - Registers fitness <= score, err_mask <= err_acc, perfect <= (score == OUT*NV).
  - If score > best_fitness: best_fitness <= score, new_best pulses.
  - done pulses; then return to IDLE.
- start in SWEEP/DONE is ignored, not queued. clear_best in SWEEP/DONE is ignored.
- Arithmetic widths:
  - The score accumulator is FW bits and cannot overflow: maximum OUT*NV.
  - Popcount is $clog2(OUT+1) bits, zero-extended.
- fitness, perfect and err_mask hold their values until the next DONE.

## Timing
- Reset values (async, immediate): state IDLE; cand_inp 0, busy 0, done 0, fitness 0, perfect 0, err_mask 0, best_fitness 0, new_best 0.
- start sampled high at edge t:
  - busy high from t+1.
  - cand_inp = v during cycle t+1+v.
  - done/new_best high during cycle t+1+NV.
  - busy falls at t+2+NV; a new start is accepted at that edge at the earliest.
- Total latency from start to done: NV+1 cycles. IN=4 gives 17 cycles.
- Outputs in DONE come from registers updated at the edge entering DONE. They are therefore valid in the same cycle as the done pulse.
- Reset asserted mid-sweep: all state is cleared at once, including best_fitness. No done is issued.
- The comparison uses cand_out in the same cycle as cand_inp, which requires the grid to be purely combinational. The timing path is cand_inp register -> grid -> comparator -> score register.

## Test plan
- Reset: pulse rst_n low mid-SWEEP (IN=4, OUT=2) -> next cycle state IDLE, busy=0, cand_inp=0, best_fitness=0, no done.
- Perfect match, IN=2 OUT=1: model cand_out = AND(inp), target=4'b1000, start -> cand_inp sequence 0,1,2,3, done at start+5, fitness=4, perfect=1, err_mask=0, new_best=1, best_fitness=4.
- Full mismatch, IN=2 OUT=1: model cand_out = NAND, target=4'b1000 -> fitness=0, perfect=0, err_mask=1, new_best=0.
- Per-output errors, IN=2 OUT=2: out0 correct, out1 wrong on vector 3 only -> fitness=7, err_mask=2'b10.
- Best tracking: evaluations scoring 5, 7, 7, 3 -> new_best pulses 1,1,0,0, best_fitness=7. Then clear_best in IDLE -> 0, and the next score of 3 gives new_best=1.
- Ignored requests: start and clear_best pulsed during SWEEP -> exactly one done, best_fitness unchanged by clear. start and clear_best together in IDLE -> best cleared and evaluation runs.

Source files
------------

// File: rtl/fitness_eval.sv
// fitness_eval
//   Sweeps every input vector into the evolvable grid and counts how many grid
//   output bits agree with a target truth table. It reports the score,
//   per-output error flags and a running best score.
//
// Ports
//   clk, rst_n    : clock and asynchronous active-low reset
//   start         : begin an evaluation; only looked at in IDLE
//   clear_best    : zero best_fitness; only looked at in IDLE
//   target        : truth table, bit k*NV+v = expected output k for vector v
//   cand_inp      : vector driven into the grid's primary inputs
//   cand_out      : grid outputs, combinational in cand_inp
//   busy          : evaluation in progress (SWEEP or DONE)
//   done          : one-cycle pulse, results below are valid
//   fitness       : matching-bit count of the last evaluation
//   perfect       : fitness equals OUT*NV
//   err_mask      : bit k set if output k ever mismatched
//   best_fitness  : maximum fitness since reset or last clear
//   new_best      : pulses with done when the score beat the previous best
//   state_dbg     : current FSM state (0 IDLE, 1 SWEEP, 2 DONE)
//
// Handshake: start is a level sampled on a rising edge while busy is low; it
// is dropped, not queued, while busy is high. done is a single-cycle pulse and
// needs no acknowledge.
module fitness_eval #(
    parameter int IN  = 4,
    parameter int OUT = 2,
    parameter int FW  = $clog2(OUT * (2 ** IN) + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear_best,
    input  logic [OUT*(2**IN)-1:0]    target,
    output logic [IN-1:0]             cand_inp,
    input  logic [OUT-1:0]            cand_out,
    output logic                      busy,
    output logic                      done,
    output logic [FW-1:0]             fitness,
    output logic                      perfect,
    output logic [OUT-1:0]            err_mask,
    output logic [FW-1:0]             best_fitness,
    output logic                      new_best,
    output logic [1:0]                state_dbg
);

    localparam int NV = 2 ** IN;
    localparam int PW = $clog2(OUT + 1);
    localparam logic [FW-1:0] MAX_SCORE = FW'(OUT * NV);
    localparam logic [IN:0]   LAST_VEC  = (IN + 1)'(NV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // One spare bit so NV-1 compares unambiguously.
    logic [IN:0]     vec;
    logic [FW-1:0]   score;
    logic [OUT-1:0]  err_acc;

    logic [NV-1:0]   tgt_row [OUT];
    logic [OUT-1:0]  exp_bits;
    logic [OUT-1:0]  match;
    logic [PW-1:0]   pop;
    logic [FW-1:0]   score_nxt;
    logic [OUT-1:0]  err_nxt;
    logic            last;

    // Regroup the flat target so each output's column is indexed by vector.
    for (genvar k = 0; k < OUT; k++) begin : g_row
        assign tgt_row[k] = target[k*NV +: NV];
    end

    assign last = (vec == LAST_VEC);

    always_comb begin
        exp_bits = '0;
        pop      = '0;
        for (int k = 0; k < OUT; k++) begin
            exp_bits[k] = tgt_row[k][vec[IN-1:0]];
        end
        match = ~(cand_out ^ exp_bits);
        for (int k = 0; k < OUT; k++) begin
            pop = pop + PW'(match[k]);
        end
        score_nxt = score + FW'(pop);
        err_nxt   = err_acc | ~match;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on the edge that enters DONE so they are valid
    // alongside the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= '0;
            score        <= '0;
            err_acc      <= '0;
            fitness      <= '0;
            perfect      <= 1'b0;
            err_mask     <= '0;
            best_fitness <= '0;
            new_best     <= 1'b0;
        end else begin
            state    <= state_nxt;
            new_best <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_best) best_fitness <= '0;
                    if (start) begin
                        vec     <= '0;
                        score   <= '0;
                        err_acc <= '0;
                    end
                end
                SWEEP: begin
                    score   <= score_nxt;
                    err_acc <= err_nxt;
                    if (last) begin
                        fitness  <= score_nxt;
                        err_mask <= err_nxt;
                        perfect  <= (score_nxt == MAX_SCORE);
                        if (score_nxt > best_fitness) begin
                            best_fitness <= score_nxt;
                            new_best     <= 1'b1;
                        end
                    end else begin
                        vec <= vec + (IN + 1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cand_inp  = (state == SWEEP) ? vec[IN-1:0] : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule
